// File: rtl/mpsoc_ahb3_mpram_arb.sv
`default_nettype none
// ============================================================================
// Module   : mpsoc_ahb3_mpram_arb
// Purpose  : Multi-port AHB3-Lite slave RAM. PORTS independent slave ports
//            share one single-ported word array. A round-robin arbiter grants
//            one memory access per cycle. Supports byte-lane writes, contention
//            wait states and two-cycle ERROR responses.
// Ports    : HCLK       clock, rising edge
//            HRESETn    synchronous active-low reset
//            HSEL       per-port slave select
//            HADDR      per-port byte address
//            HWDATA     per-port write data (data phase)
//            HRDATA     per-port read data
//            HWRITE     per-port write strobe
//            HSIZE      per-port transfer size (2^HSIZE bytes)
//            HTRANS     per-port transfer type
//            HREADY     per-port bus ready
//            HREADYOUT  per-port slave ready
//            HRESP      per-port response (0=OKAY, 1=ERROR)
// Revision : 1.0 - initial release
// ============================================================================
module mpsoc_ahb3_mpram_arb #(
   parameter int PORTS     = 8,
   parameter int XLEN      = 64,
   parameter int PLEN      = 64,
   parameter int MEM_DEPTH = 256
) (
   input  logic                             HCLK,
   input  logic                             HRESETn,
   input  logic [PORTS-1:0]                 HSEL,
   input  logic [PORTS-1:0][PLEN-1:0]       HADDR,
   input  logic [PORTS-1:0][XLEN-1:0]       HWDATA,
   output logic [PORTS-1:0][XLEN-1:0]       HRDATA,
   input  logic [PORTS-1:0]                 HWRITE,
   input  logic [PORTS-1:0][2:0]            HSIZE,
   input  logic [PORTS-1:0][1:0]            HTRANS,
   input  logic [PORTS-1:0]                 HREADY,
   output logic [PORTS-1:0]                 HREADYOUT,
   output logic [PORTS-1:0]                 HRESP
);

   localparam int NB        = XLEN / 8;
   localparam int B         = $clog2(NB);
   localparam int AW        = $clog2(MEM_DEPTH);
   localparam int PW        = (PORTS > 1) ? $clog2(PORTS) : 1;
   localparam int MEM_BYTES = MEM_DEPTH * NB;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PEND = 3'd1,
      S_DONE = 3'd2,
      S_ERR1 = 3'd3,
      S_ERR2 = 3'd4
   } state_t;

   // per-port state and captured address phase
   state_t            state_q [PORTS];
   state_t            state_d [PORTS];
   logic [AW-1:0]     idx_q   [PORTS];
   logic [NB-1:0]     be_q    [PORTS];
   logic [PORTS-1:0]  wr_q;
   logic [XLEN-1:0]   rdata_q [PORTS];

   // shared memory and arbiter
   logic [XLEN-1:0]   mem_q [MEM_DEPTH];
   logic [PW-1:0]     ptr_q;

   // decode results per port
   logic [PORTS-1:0]  w_err;
   logic [PORTS-1:0]  w_accept;
   logic [PORTS-1:0]  w_req;
   logic [PORTS-1:0]  w_htrans0;
   logic [NB-1:0]     w_be [PORTS];

   // granted access
   logic              w_gnt_vld;
   logic [PW-1:0]     w_gnt;
   logic [AW-1:0]     w_gidx;
   logic [NB-1:0]     w_gbe;
   logic              w_gwr;
   logic [XLEN-1:0]   w_gdata;
   logic [XLEN-1:0]   w_rword;
   logic              w_unused_trans;

   for (genvar p = 0; p < PORTS; p++) begin : g_port
      logic [B-1:0]  l_off;
      logic [B-1:0]  l_mask;
      logic [NB-1:0] l_be;
      logic          l_err;

      assign l_off = HADDR[p][B-1:0];

      always_comb begin
         // low address bits that must be zero for a naturally aligned transfer
         l_mask = '0;
         for (int b = 0; b < B; b++) begin
            l_mask[b] = (b < int'(HSIZE[p]));
         end
         l_err = (HADDR[p] >= PLEN'(MEM_BYTES)) ||
                 (HSIZE[p] > 3'(B)) ||
                 ((l_off & l_mask) != '0);
         // a lane is enabled when it falls in the same 2^HSIZE-byte block as the address
         l_be = '0;
         for (int l = 0; l < NB; l++) begin
            if ((l >> HSIZE[p]) == (int'(l_off) >> HSIZE[p])) begin
               l_be[l] = 1'b1;
            end
         end
      end

      assign w_err[p]     = l_err;
      assign w_be[p]      = l_be;
      // new address phases are only taken while the slave is ready on this port
      assign w_accept[p]  = HSEL[p] & HREADY[p] & HTRANS[p][1] &
                            ((state_q[p] == S_IDLE) || (state_q[p] == S_DONE) ||
                             (state_q[p] == S_ERR2));
      assign w_req[p]     = (state_q[p] == S_PEND);
      assign w_htrans0[p] = HTRANS[p][0];
      assign HRDATA[p]    = rdata_q[p];
   end

   // SEQ and NONSEQ are handled identically, so HTRANS[0] carries no information
   assign w_unused_trans = ^w_htrans0;

   // round robin: first requesting port strictly after the pointer
   always_comb begin
      int idx;
      idx       = 0;
      w_gnt_vld = 1'b0;
      w_gnt     = '0;
      for (int i = 1; i <= PORTS; i++) begin
         idx = (int'(ptr_q) + i) % PORTS;
         if (!w_gnt_vld && w_req[idx]) begin
            w_gnt_vld = 1'b1;
            w_gnt     = PW'(idx);
         end
      end
   end

   assign w_gidx  = idx_q[w_gnt];
   assign w_gbe   = be_q[w_gnt];
   assign w_gwr   = wr_q[w_gnt];
   assign w_gdata = HWDATA[w_gnt];
   assign w_rword = mem_q[w_gidx];

   // per-port next state and outputs
   always_comb begin
      HREADYOUT = '1;
      HRESP     = '0;
      for (int p = 0; p < PORTS; p++) begin
         state_d[p] = state_q[p];
         case (state_q[p])
            S_IDLE, S_DONE, S_ERR2: begin
               if (state_q[p] == S_ERR2) begin
                  HRESP[p] = 1'b1;
               end
               if (w_accept[p]) begin
                  state_d[p] = w_err[p] ? S_ERR1 : S_PEND;
               end else begin
                  state_d[p] = S_IDLE;
               end
            end
            S_PEND: begin
               HREADYOUT[p] = 1'b0;
               if (w_gnt_vld && (w_gnt == PW'(p))) begin
                  state_d[p] = S_DONE;
               end
            end
            S_ERR1: begin
               HREADYOUT[p] = 1'b0;
               HRESP[p]     = 1'b1;
               state_d[p]   = S_ERR2;
            end
            default: begin
               state_d[p] = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         ptr_q <= PW'(PORTS - 1);
         wr_q  <= '0;
         for (int p = 0; p < PORTS; p++) begin
            state_q[p] <= S_IDLE;
            idx_q[p]   <= '0;
            be_q[p]    <= '0;
            rdata_q[p] <= '0;
         end
      end else begin
         if (w_gnt_vld) begin
            ptr_q <= w_gnt;
         end
         for (int p = 0; p < PORTS; p++) begin
            state_q[p] <= state_d[p];
            if (w_accept[p]) begin
               idx_q[p] <= HADDR[p][AW+B-1:B];
               be_q[p]  <= w_be[p];
               wr_q[p]  <= HWRITE[p];
            end
            if (w_gnt_vld && (w_gnt == PW'(p)) && !wr_q[p]) begin
               rdata_q[p] <= w_rword;
            end
         end
      end
   end

   // memory array is never cleared; a write granted in a reset cycle is dropped
   always_ff @(posedge HCLK) begin
      if (HRESETn && w_gnt_vld && w_gwr) begin
         for (int l = 0; l < NB; l++) begin
            if (w_gbe[l]) begin
               mem_q[w_gidx][l*8 +: 8] <= w_gdata[l*8 +: 8];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mpsoc_ahb3_mpram_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mpsoc_ahb3_mpram_arb
// Purpose  : Self-checking bench for mpsoc_ahb3_mpram_arb. Each issued
//            transfer pushes its expected completion (cycle, response, read
//            data) onto a per-port queue; a monitor pops and compares when the
//            port signals HREADYOUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mpsoc_ahb3_mpram_arb;

   localparam int PORTS     = 8;
   localparam int XLEN      = 64;
   localparam int PLEN      = 64;
   localparam int MEM_DEPTH = 256;

   logic                        HCLK = 1'b0;
   logic                        HRESETn;
   logic [PORTS-1:0]            HSEL;
   logic [PORTS-1:0][PLEN-1:0]  HADDR;
   logic [PORTS-1:0][XLEN-1:0]  HWDATA;
   logic [PORTS-1:0][XLEN-1:0]  HRDATA;
   logic [PORTS-1:0]            HWRITE;
   logic [PORTS-1:0][2:0]       HSIZE;
   logic [PORTS-1:0][1:0]       HTRANS;
   logic [PORTS-1:0]            HREADY;
   logic [PORTS-1:0]            HREADYOUT;
   logic [PORTS-1:0]            HRESP;

   always #5 HCLK = ~HCLK;

   // single slave on each port's bus, so bus ready follows slave ready
   assign HREADY = HREADYOUT;

   mpsoc_ahb3_mpram_arb #(
      .PORTS    (PORTS),
      .XLEN     (XLEN),
      .PLEN     (PLEN),
      .MEM_DEPTH(MEM_DEPTH)
   ) u_dut (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .HSEL     (HSEL),
      .HADDR    (HADDR),
      .HWDATA   (HWDATA),
      .HRDATA   (HRDATA),
      .HWRITE   (HWRITE),
      .HSIZE    (HSIZE),
      .HTRANS   (HTRANS),
      .HREADY   (HREADY),
      .HREADYOUT(HREADYOUT),
      .HRESP    (HRESP)
   );

   typedef struct {
      int              cyc;
      logic            resp;
      logic            chk;
      logic [XLEN-1:0] data;
   } exp_t;

   exp_t            exp_q [PORTS][$];
   int              cyc = 0;
   int              n_vec = 0;
   int              n_err = 0;
   int              issue_cyc [PORTS];
   logic [XLEN-1:0] wd_pend [PORTS];
   logic [PORTS-1:0] aph = '0;

   always @(posedge HCLK) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [XLEN-1:0] act,
                            input logic [XLEN-1:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, act, expv);
      end
   endtask

   // completion monitor
   always @(negedge HCLK) begin
      exp_t e;
      for (int p = 0; p < PORTS; p++) begin
         if (exp_q[p].size() > 0 && cyc > issue_cyc[p]) begin
            e = exp_q[p][0];
            if (HREADYOUT[p]) begin
               void'(exp_q[p].pop_front());
               check_val($sformatf("p%0d_done_cycle", p), XLEN'(cyc), XLEN'(e.cyc));
               check_val($sformatf("p%0d_done_resp", p), XLEN'(HRESP[p]), XLEN'(e.resp));
               if (e.chk) begin
                  check_val($sformatf("p%0d_rdata", p), HRDATA[p], e.data);
               end
            end else begin
               check_val($sformatf("p%0d_wait_resp", p), XLEN'(HRESP[p]), XLEN'(e.resp));
            end
         end
      end
   end

   function automatic logic [PORTS-1:0] busy_mask();
      logic [PORTS-1:0] m;
      m = '0;
      for (int p = 0; p < PORTS; p++) m[p] = (exp_q[p].size() != 0);
      return m;
   endfunction

   // drive an address phase on port p this cycle and queue its expected completion
   task automatic req(input int p, input logic wr, input logic [PLEN-1:0] a,
                      input logic [2:0] sz, input logic [XLEN-1:0] wd, input int lat,
                      input logic resp, input logic chk, input logic [XLEN-1:0] rd);
      exp_t e;
      HSEL[p]      = 1'b1;
      HTRANS[p]    = 2'b10;
      HADDR[p]     = a;
      HWRITE[p]    = wr;
      HSIZE[p]     = sz;
      wd_pend[p]   = wd;
      aph[p]       = 1'b1;
      issue_cyc[p] = cyc;
      e.cyc  = cyc + lat;
      e.resp = resp;
      e.chk  = chk;
      e.data = rd;
      exp_q[p].push_back(e);
   endtask

   // advance one cycle; ports that just had an address phase enter the data phase
   task automatic step();
      @(posedge HCLK);
      #1;
      for (int p = 0; p < PORTS; p++) begin
         if (aph[p]) begin
            HSEL[p]   = 1'b0;
            HTRANS[p] = 2'b00;
            HWDATA[p] = wd_pend[p];
            aph[p]    = 1'b0;
         end
      end
   endtask

   task automatic wait_all();
      int n;
      n = 0;
      step();
      while (busy_mask() != '0 && n < 60) begin
         step();
         n++;
      end
      if (busy_mask() != '0) begin
         check_val("timeout_pending", XLEN'(busy_mask()), '0);
         for (int p = 0; p < PORTS; p++) exp_q[p].delete();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      HRESETn = 1'b0;
      HSEL    = '0;
      HADDR   = '0;
      HWDATA  = '0;
      HWRITE  = '0;
      HSIZE   = '0;
      HTRANS  = '0;
      for (int p = 0; p < PORTS; p++) issue_cyc[p] = 0;
      repeat (3) @(posedge HCLK);
      #1;
      check_val("rst_hreadyout", XLEN'(HREADYOUT), XLEN'({PORTS{1'b1}}));
      check_val("rst_hresp", XLEN'(HRESP), '0);
      for (int p = 0; p < PORTS; p++) begin
         check_val($sformatf("rst_hrdata%0d", p), HRDATA[p], '0);
      end
      HRESETn = 1'b1;

      // full contention right after reset: port p completes at A+2+p
      for (int p = 0; p < PORTS; p++) begin
         req(p, 1'b0, PLEN'(32'h200 + p * 8), 3'd3, '0, 2 + p, 1'b0, 1'b0, '0);
      end
      wait_all();

      // single-port write then read, one wait state each
      req(0, 1'b1, 'h10, 3'd3, 64'hDEADBEEF_CAFEF00D, 2, 1'b0, 1'b0, '0);
      wait_all();
      req(0, 1'b0, 'h10, 3'd3, '0, 2, 1'b0, 1'b1, 64'hDEADBEEF_CAFEF00D);
      wait_all();

      // byte write into a zeroed word; only lane 3 may change
      req(0, 1'b1, 'h18, 3'd3, '0, 2, 1'b0, 1'b0, '0);
      wait_all();
      req(3, 1'b1, 'h1B, 3'd0, 64'h11111111_AB111111, 2, 1'b0, 1'b0, '0);
      wait_all();
      req(3, 0, 'h18, 3'd3, '0, 2, 1'b0, 1'b1, 64'h00000000_AB000000);
      wait_all();

      // error responses; 0x800 aliases word 0 in the index bits, so word 0 must survive
      req(2, 1'b1, 'h0, 3'd3, 64'h01234567_89ABCDEF, 2, 1'b0, 1'b0, '0);
      wait_all();
      req(2, 1'b0, 'h800, 3'd3, '0, 2, 1'b1, 1'b0, '0);
      wait_all();
      req(2, 1'b1, 'h02, 3'd2, 64'hFFFFFFFF_FFFFFFFF, 2, 1'b1, 1'b0, '0);
      wait_all();
      req(2, 1'b1, 'h800, 3'd3, 64'hFFFFFFFF_FFFFFFFF, 2, 1'b1, 1'b0, '0);
      wait_all();
      req(2, 1'b1, 'h0, 3'd4, 64'hFFFFFFFF_FFFFFFFF, 2, 1'b1, 1'b0, '0);
      wait_all();
      req(2, 1'b0, 'h0, 3'd3, '0, 2, 1'b0, 1'b1, 64'h01234567_89ABCDEF);
      wait_all();

      // same-word race with pointer at 3: port 5 wins, port 2 lands last
      req(3, 1'b0, 'h40, 3'd3, '0, 2, 1'b0, 1'b0, '0);
      wait_all();
      req(2, 1'b1, 'h40, 3'd3, 64'h22222222_22222222, 3, 1'b0, 1'b0, '0);
      req(5, 1'b1, 'h40, 3'd3, 64'h55555555_55555555, 2, 1'b0, 1'b0, '0);
      wait_all();
      req(0, 1'b0, 'h40, 3'd3, '0, 2, 1'b0, 1'b1, 64'h22222222_22222222);
      wait_all();
      // read data holds across a following write
      req(0, 1'b1, 'h48, 3'd3, 64'h0BADF00D_0BADF00D, 2, 1'b0, 1'b0, '0);
      wait_all();
      check_val("hrdata_hold", HRDATA[0], 64'h22222222_22222222);

      // reset while port 1 write is pending behind port 0
      req(0, 1'b1, 'h100, 3'd3, 64'hA0A0A0A0_A0A0A0A0, 2, 1'b0, 1'b0, '0);
      wait_all();
      req(1, 1'b1, 'h108, 3'd3, 64'hA1A1A1A1_A1A1A1A1, 2, 1'b0, 1'b0, '0);
      wait_all();
      // pointer now 1; ports 0 and 1 together -> port 0 first (after 1 comes 2..7,0)
      req(0, 1'b1, 'h100, 3'd3, 64'hC0C0C0C0_C0C0C0C0, 2, 1'b0, 1'b0, '0);
      req(1, 1'b1, 'h108, 3'd3, 64'hC1C1C1C1_C1C1C1C1, 3, 1'b0, 1'b0, '0);
      step();
      step();
      HRESETn = 1'b0;
      step();
      check_val("midrst_hreadyout", XLEN'(HREADYOUT), XLEN'({PORTS{1'b1}}));
      check_val("midrst_hresp", XLEN'(HRESP), '0);
      HRESETn = 1'b1;
      wait_all();
      // pointer back at PORTS-1 gives port 0 priority over port 1
      req(1, 1'b0, 'h108, 3'd3, '0, 3, 1'b0, 1'b1, 64'hA1A1A1A1_A1A1A1A1);
      req(0, 1'b0, 'h100, 3'd3, '0, 2, 1'b0, 1'b1, 64'hC0C0C0C0_C0C0C0C0);
      wait_all();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
